// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared datapath types for the writeback port arbiter
package mips_cpu_pkg;
  typedef logic [31:0] word_t;
  typedef logic [63:0] double_word_t;
  typedef enum logic [4:0] {
    R_ZERO, R_AT, R_V0, R_V1, R_A0, R_A1, R_A2, R_A3,
    R_T0, R_T1, R_T2, R_T3, R_T4, R_T5, R_T6, R_T7,
    R_S0, R_S1, R_S2, R_S3, R_S4, R_S5, R_S6, R_S7,
    R_T8, R_T9, R_K0, R_K1, R_GP, R_SP, R_FP, R_RA
  } reg_enum;
  typedef enum logic {WB_RF, WB_HILO} wb_kind_enum;
  typedef struct packed {
    wb_kind_enum  kind;
    reg_enum      rfwa;
    double_word_t data;
  } llu_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: in-order FIFO exposing count and every slot with its validity
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                din,
  output logic [W-1:0]                dout,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0][W-1:0]     entries,
  output logic [DEPTH-1:0]            valid
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  // pointers and occupancy; caller guarantees no push when full, no pop when empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage needs no reset; validity comes from the pointers
  always_ff @(posedge clk)
    if (push) entries[wr_ptr] <= din;
  assign dout = entries[rd_ptr];
  // a slot is live when its distance from the read pointer is below the count
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, AW'(i) - rd_ptr} < count;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares regfile and HI/LO write ports between writeback and a long-latency unit
module wb_port_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_rfwe,
  input  reg_enum      pipe_rfwa,
  input  word_t        pipe_rfwd,
  input  logic         pipe_hilowe,
  input  word_t        pipe_hi,
  input  word_t        pipe_lo,
  input  logic         llu_valid,
  output logic         llu_ready,
  input  logic         llu_is_hilo,
  input  reg_enum      llu_rfwa,
  input  double_word_t llu_data,
  output logic         rfwe,
  output reg_enum      rfwa,
  output word_t        rfwd,
  output logic         hilowe,
  output word_t        hi_i,
  output word_t        lo_i,
  output logic         stall_pipe,
  output logic [31:0]  pend_mask,
  output logic         hilo_pend
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  llu_entry_t in_ent, head;
  llu_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0] slot_valid;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic head_valid, head_rf, drain, blocked, push;
  assign in_ent     = '{kind: wb_kind_enum'(llu_is_hilo), rfwa: llu_rfwa, data: llu_data};
  assign llu_ready  = count < CW'(DEPTH);
  assign push       = llu_valid && llu_ready;
  assign head_valid = count != '0;
  assign head_rf    = head.kind == WB_RF;
  assign drain      = head_valid && (head_rf ? !pipe_rfwe : !pipe_hilowe);
  assign blocked    = head_valid && !drain;
  sync_fifo #(.W($bits(llu_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(drain), .din(in_ent),
    .dout(head), .count(count), .entries(slots), .valid(slot_valid)
  );
  // pipeline owns a port whenever it writes it; a $zero-targeted head drains silently
  always_comb begin
    rfwe   = pipe_rfwe || (drain && head_rf && head.rfwa != R_ZERO);
    rfwa   = pipe_rfwe ? pipe_rfwa : head.rfwa;
    rfwd   = pipe_rfwe ? pipe_rfwd : head.data[31:0];
    hilowe = pipe_hilowe || (drain && !head_rf);
    hi_i   = pipe_hilowe ? pipe_hi : head.data[63:32];
    lo_i   = pipe_hilowe ? pipe_lo : head.data[31:0];
  end
  // starvation guard: stall raised as the blocked count reaches MAX_WAIT-1, dropped on drain
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt   <= '0;
      stall_pipe <= 1'b0;
    end else begin
      wait_cnt   <= !blocked ? '0 : wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + WW'(1);
      stall_pipe <= drain ? 1'b0 : (blocked && wait_cnt == WW'(MAX_WAIT - 2)) ? 1'b1 : stall_pipe;
    end
  // pending destinations for the decode interlock; $zero never reported
  always_comb begin
    pend_mask = '0;
    hilo_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && slots[i].kind == WB_RF) pend_mask[slots[i].rfwa] = 1'b1;
      if (slot_valid[i] && slots[i].kind == WB_HILO) hilo_pend = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for the writeback port arbiter
module tb_wb_port_arbiter;
  import mips_cpu_pkg::*;
  logic clk, rst, pipe_rfwe, pipe_hilowe, llu_valid, llu_ready, llu_is_hilo;
  logic rfwe, hilowe, stall_pipe, hilo_pend;
  reg_enum pipe_rfwa, llu_rfwa, rfwa;
  word_t pipe_rfwd, pipe_hi, pipe_lo, rfwd, hi_i, lo_i;
  double_word_t llu_data;
  logic [31:0] pend_mask;
  int total = 0, bad = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .pipe_rfwe(pipe_rfwe), .pipe_rfwa(pipe_rfwa), .pipe_rfwd(pipe_rfwd),
    .pipe_hilowe(pipe_hilowe), .pipe_hi(pipe_hi), .pipe_lo(pipe_lo), .llu_valid(llu_valid),
    .llu_ready(llu_ready), .llu_is_hilo(llu_is_hilo), .llu_rfwa(llu_rfwa), .llu_data(llu_data),
    .rfwe(rfwe), .rfwa(rfwa), .rfwd(rfwd), .hilowe(hilowe), .hi_i(hi_i), .lo_i(lo_i),
    .stall_pipe(stall_pipe), .pend_mask(pend_mask), .hilo_pend(hilo_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic llu(input logic v, input logic hl, input logic [4:0] a, input logic [63:0] d);
    llu_valid = v;
    llu_is_hilo = hl;
    llu_rfwa = reg_enum'(a);
    llu_data = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe_rfwe = 0; pipe_rfwa = R_ZERO; pipe_rfwd = '0;
    pipe_hilowe = 0; pipe_hi = '0; pipe_lo = '0;
    llu(0, 0, 5'd0, 64'd0);
    #2;
    chk("rst_ready", 64'(llu_ready), 64'd1);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_hpend", 64'(hilo_pend), 64'd0);
    chk("rst_rfwe", 64'(rfwe), 64'd0);
    chk("rst_hilowe", 64'(hilowe), 64'd0);
    chk("rst_stall", 64'(stall_pipe), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    // single regfile result, pipe idle
    llu(1, 0, 5'd5, 64'h1234);
    #1;
    chk("t1_nobypass", 64'(rfwe), 64'd0);
    tick;
    llu(0, 0, 5'd0, 64'd0);
    #1;
    chk("t1_rfwe", 64'(rfwe), 64'd1);
    chk("t1_rfwa", 64'(rfwa), 64'd5);
    chk("t1_rfwd", 64'(rfwd), 64'h1234);
    chk("t1_pend", 64'(pend_mask), 64'h20);
    tick;
    chk("t1_rfwe_after", 64'(rfwe), 64'd0);
    chk("t1_pend_after", 64'(pend_mask), 64'd0);
    // pipe hogs the regfile port, starvation guard kicks in
    pipe_rfwe = 1; pipe_rfwa = reg_enum'(5'd3); pipe_rfwd = 32'hCAFE;
    llu(1, 0, 5'd7, 64'h77);
    tick;
    llu(0, 0, 5'd0, 64'd0);
    #1;
    chk("t2_pipe_rfwa", 64'(rfwa), 64'd3);
    chk("t2_pipe_rfwd", 64'(rfwd), 64'hCAFE);
    chk("t2_pend", 64'(pend_mask), 64'h80);
    for (int i = 0; i < 6; i++) tick;
    chk("t2_stall_early", 64'(stall_pipe), 64'd0);
    tick;
    chk("t2_stall_set", 64'(stall_pipe), 64'd1);
    pipe_rfwe = 0;
    #1;
    chk("t2_drain_rfwe", 64'(rfwe), 64'd1);
    chk("t2_drain_rfwa", 64'(rfwa), 64'd7);
    chk("t2_drain_rfwd", 64'(rfwd), 64'h77);
    tick;
    chk("t2_stall_clr", 64'(stall_pipe), 64'd0);
    chk("t2_pend_clr", 64'(pend_mask), 64'd0);
    // HI/LO result waits behind a blocked regfile head
    pipe_rfwe = 1;
    llu(1, 0, 5'd9, 64'h99);
    tick;
    llu(1, 1, 5'd0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick;
    llu(0, 0, 5'd0, 64'd0);
    #1;
    chk("t3_hilo_wait", 64'(hilowe), 64'd0);
    chk("t3_hpend", 64'(hilo_pend), 64'd1);
    chk("t3_pend", 64'(pend_mask), 64'h200);
    tick;
    chk("t3_hilo_wait2", 64'(hilowe), 64'd0);
    pipe_rfwe = 0;
    #1;
    chk("t3_rf_first", 64'(rfwe), 64'd1);
    chk("t3_rf_rfwa", 64'(rfwa), 64'd9);
    chk("t3_hilo_not_yet", 64'(hilowe), 64'd0);
    tick;
    chk("t3_hilowe", 64'(hilowe), 64'd1);
    chk("t3_hi", 64'(hi_i), 64'hAAAABBBB);
    chk("t3_lo", 64'(lo_i), 64'hCCCCDDDD);
    chk("t3_rfwe_off", 64'(rfwe), 64'd0);
    tick;
    chk("t3_hpend_clr", 64'(hilo_pend), 64'd0);
    chk("t3_hilowe_off", 64'(hilowe), 64'd0);
    // fill the FIFO, then drain and enqueue together
    pipe_rfwe = 1;
    for (int i = 0; i < 4; i++) begin
      llu(1, 0, 5'(10 + i), 64'(16'h100 + i));
      tick;
    end
    llu(1, 0, 5'd14, 64'h104);
    #1;
    chk("t4_full_ready", 64'(llu_ready), 64'd0);
    tick;
    chk("t4_count4", 64'(dut.u_fifo.count), 64'd4);
    chk("t4_pend", 64'(pend_mask), 64'h3C00);
    llu(0, 0, 5'd0, 64'd0);
    pipe_rfwe = 0;
    #1;
    chk("t4_head_rfwa", 64'(rfwa), 64'd10);
    chk("t4_head_rfwd", 64'(rfwd), 64'h100);
    tick;
    chk("t4_ready_back", 64'(llu_ready), 64'd1);
    llu(1, 0, 5'd14, 64'h104);
    #1;
    chk("t4_next_rfwa", 64'(rfwa), 64'd11);
    tick;
    llu(0, 0, 5'd0, 64'd0);
    #1;
    chk("t4_count3", 64'(dut.u_fifo.count), 64'd3);
    chk("t4_pend3", 64'(pend_mask), 64'h7000);
    for (int i = 0; i < 3; i++) tick;
    chk("t4_empty", 64'(dut.u_fifo.count), 64'd0);
    chk("t4_pend_empty", 64'(pend_mask), 64'd0);
    // result to $zero drains without a write
    llu(1, 0, 5'd0, 64'h55);
    tick;
    llu(0, 0, 5'd0, 64'd0);
    #1;
    chk("t5_zero_rfwe", 64'(rfwe), 64'd0);
    chk("t5_zero_pend", 64'(pend_mask), 64'd0);
    chk("t5_zero_queued", 64'(dut.u_fifo.count), 64'd1);
    tick;
    chk("t5_zero_drained", 64'(dut.u_fifo.count), 64'd0);
    // reset with three entries queued discards them
    pipe_rfwe = 1;
    llu(1, 0, 5'd20, 64'h20);
    tick;
    llu(1, 0, 5'd21, 64'h21);
    tick;
    llu(1, 1, 5'd0, 64'h1111_2222_3333_4444);
    tick;
    llu(0, 0, 5'd0, 64'd0);
    #1;
    chk("t6_pend_pre", 64'(pend_mask), 64'h300000);
    chk("t6_hpend_pre", 64'(hilo_pend), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_ready", 64'(llu_ready), 64'd1);
    chk("t6_pend", 64'(pend_mask), 64'd0);
    chk("t6_hpend", 64'(hilo_pend), 64'd0);
    pipe_rfwe = 0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t6_no_rfwe", 64'(rfwe), 64'd0);
      chk("t6_no_hilowe", 64'(hilowe), 64'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port and the single HI/LO write port between the in-order pipeline writeback stage and one long-latency unit (LLU), such as an iterative divider or an uncached load engine.
- The pipeline always has priority. LLU results queue in an in-order FIFO and drain into free write-port cycles.
- A starvation guard stalls the pipeline so that a waiting LLU result gets a free slot.
- Sits between the writeback stage outputs and the regfile/hilo write ports; exports a pending-destination mask for the decode-stage interlock.

Parameters:
- DEPTH, 4, LLU result FIFO entries; power of two, >= 2.
- MAX_WAIT, 8, cycles a FIFO head may stay blocked before stall_pipe is raised; >= 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pipe_rfwe  in  1  writeback stage regfile write enable.
- pipe_rfwa  in  reg_enum  writeback stage regfile write address.
- pipe_rfwd  in  word_t  writeback stage regfile write data.
- pipe_hilowe  in  1  writeback stage HI/LO write enable.
- pipe_hi  in  word_t  writeback stage HI value.
- pipe_lo  in  word_t  writeback stage LO value.
- llu_valid  in  1  LLU result valid.
- llu_ready  out  1  arbiter accepts an LLU result this cycle.
- llu_is_hilo  in  1  1 = result targets HI/LO, 0 = result targets regfile.
- llu_rfwa  in  reg_enum  destination register for a regfile result.
- llu_data  in  double_word_t  result; regfile uses [31:0], HI = [63:32], LO = [31:0].
- rfwe  out  1  regfile write enable.
- rfwa  out  reg_enum  regfile write address.
- rfwd  out  word_t  regfile write data.
- hilowe  out  1  HI/LO write enable.
- hi_i  out  word_t  HI write data.
- lo_i  out  word_t  LO write data.
- stall_pipe  out  1  requests that the pipeline insert a writeback bubble.
- pend_mask  out  32  bit n = 1 when a queued regfile result targets register n.
- hilo_pend  out  1  a queued HI/LO result exists.

Behaviour:
- Reset (asynchronous):
  - FIFO is emptied; read/write pointers and count go to 0.
  - Wait counter goes to 0; stall_pipe = 0.
  - Combinationally after reset: llu_ready = 1, pend_mask = 0, hilo_pend = 0, rfwe = 0, hilowe = 0.
  - Reset mid-operation discards all queued results; no write is emitted for them.
- Enqueue:
  - Occurs on the edge where llu_valid && llu_ready.
  - llu_ready = (count < DEPTH), computed from registered count only; it does not depend on a same-cycle drain.
  - Enqueue and drain in the same cycle leave count unchanged.
- No bypass: an LLU result is written at the earliest one cycle after acceptance.
- Drain rule (only the FIFO head is considered; strictly in order):
  - Regfile-kind head drains when pipe_rfwe = 0. HI/LO-kind head drains when pipe_hilowe = 0.
  - A blocked head blocks all younger entries, even if their port is free.
- Output mux (combinational):
  - rfwe/rfwa/rfwd = pipe_* when pipe_rfwe = 1; otherwise the head values when a regfile-kind head drains; otherwise rfwe = 0.
  - hilowe/hi_i/lo_i follow the same rule on the HI/LO port.
  - The pipeline and the FIFO may write different ports in the same cycle.
- Register $zero: a regfile-kind head with rfwa = 0 drains normally, but rfwe is held at 0 for that write.
- Wait counter:
  - Cleared on drain or when the FIFO is empty.
  - Increments, saturating at MAX_WAIT, each cycle a head is valid and blocked.
- stall_pipe (registered):
  - Set on the edge where the counter advances to MAX_WAIT-1.
  - Cleared on the edge where the head drains.
  - The pipeline must respond with pipe_*we = 0. If it writes anyway, pipeline priority still holds and nothing is lost.
- pend_mask / hilo_pend:
  - Combinational OR over valid entries; bit 0 is always 0.
  - An entry's bit clears in the cycle after it drains.
  - Duplicate destinations are allowed; the bit stays set until the last such entry drains.
- Ordering guarantee: LLU results to the same register are written in acceptance order. The pipeline versus LLU WAW ordering is the decode-stage interlock's responsibility, using pend_mask.

Decomposition:
- mips_cpu_pkg: add wb_kind_enum {WB_RF, WB_HILO} and struct llu_entry_t {kind, rfwa, data}.
- Reuse the existing word_t, double_word_t and reg_enum.
- One sub-module: sync_fifo (parameterised width/depth, with count and per-entry visibility for the pending mask).

Test Plan:
- Reset, then one LLU regfile result (rfwa = 5, data = 0x1234) with pipe idle -> rfwe = 1, rfwa = 5, rfwd = 0x1234 exactly one cycle after acceptance; pend_mask[5] high for that one cycle.
- Pipe writes regfile every cycle, LLU result queued -> no LLU write; stall_pipe rises after MAX_WAIT-1 = 7 blocked cycles; pipe bubble -> result drains; stall_pipe clears next edge.
- Queue a HI/LO result (0xAAAA_BBBB_CCCC_DDDD) behind a regfile result while pipe_rfwe = 1 and pipe_hilowe = 0 -> HI/LO write waits (in-order); both drain in order once pipe_rfwe drops.
- Enqueue 4 results with the port blocked -> llu_ready = 0 on the 5th; a simultaneous drain+enqueue at count 3 keeps count 3.
- LLU result to $zero -> drains with rfwe = 0; pend_mask stays 0.
- Assert rst with 3 entries queued -> llu_ready = 1, pend_mask = 0, no writes emitted afterwards.
